ofm_tx_sched: RTL and testbench

//  Transmit-side frame sequencer in the tx_clk domain, on the read side of the outbound ctrl/data FIFO pair.
//  - Per frame: pops one 64-bit descriptor, then streams that frame's 73-bit data words to the MAC as AXI-Stream.
//  - Checks each frame's length against its descriptor and drops flagged frames.
//  - Enforces a minimum idle gap between frames and keeps frame statistics.

---
 rtl/ofm_pkg.sv | 30 +++
 rtl/ofm_axis_skid.sv | 45 ++++
 rtl/ofm_tx_sched.sv | 157 +++++++++++++++
 tb/tb_ofm_tx_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_pkg.sv
// Shared definitions for the outbound transmit path: sequencer state encoding,
// descriptor/data FIFO word layouts and the beat carried through the output buffer.
package ofm_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, DROP, GAP} tx_state_t;

    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = 16;
    localparam int DROP_BIT = 16;
    localparam int KEEP_LSB = 64;
    localparam int LAST_BIT = 72;

    typedef struct packed {
        logic        user;
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } axis_beat_t;

    localparam int BEAT_W = $bits(axis_beat_t);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        // NOTE: blocking '=' is correct here: n is a local temporary, not a flop.
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/ofm_axis_skid.sv
// Two-entry valid/ready buffer. Output and space flag are both straight from flops,
// so the producer can decide a pop without looking at the downstream ready.
module ofm_axis_skid #(
    parameter int WIDTH = 74
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             empty
);

    logic             s_valid;
    logic [WIDTH-1:0] s_data;

    assign out_ready = ~s_valid;
    assign empty     = ~m_valid & ~s_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            // NOTE: payload registers are reset as well because they drive top-level outputs that must read 0.
            m_data  <= '0;
            s_data  <= '0;
        end else if (!m_valid || m_ready) begin
            if (s_valid) begin
                m_data  <= s_data;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else begin
                m_valid <= in_valid;
                if (in_valid) m_data <= in_data;
            end
        end else if (in_valid) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
        end
    end

endmodule

// File: rtl/ofm_tx_sched.sv
// Transmit frame sequencer: pops a descriptor, streams its data words to the MAC,
// checks length, discards flagged frames and enforces the inter-frame gap.
module ofm_tx_sched
    import ofm_pkg::*;
#(
    parameter int C_IFG_CYCLES = 3,
    parameter int C_MAX_BYTES  = 9600
) (
    input  logic        tx_clk,
    input  logic        tx_resetn,
    input  logic        enable,
    input  logic [63:0] ctrl_fifo_rdata,
    input  logic        ctrl_fifo_empty,
    output logic        ctrl_fifo_rden,
    input  logic [72:0] data_fifo_rdata,
    input  logic        data_fifo_empty,
    output logic        data_fifo_rden,
    output logic [63:0] tx_axis_tdata,
    output logic [7:0]  tx_axis_tkeep,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tuser,
    output logic        tx_axis_tvalid,
    input  logic        tx_axis_tready,
    output logic        busy,
    output logic        len_err,
    output logic [31:0] stat_frames,
    output logic [15:0] stat_drops,
    output logic [15:0] stat_len_errs
);

    localparam logic [16:0] MAX_BYTES = 17'(C_MAX_BYTES);
    localparam logic [16:0] SAT_BYTES = 17'(C_MAX_BYTES + 8);
    localparam logic [7:0]  IFG_LAST  = 8'(C_IFG_CYCLES - 1);

    tx_state_t   state;
    logic [15:0] frame_len;
    logic        frame_drop;
    logic [16:0] byte_cnt;
    logic [7:0]  gap_cnt;

    logic        skid_ready, skid_empty, skid_valid;
    axis_beat_t  skid_in, skid_out;

    logic [7:0]  word_keep;
    logic        word_last;
    logic [16:0] byte_sum, byte_cnt_new;
    logic        len_bad, over_max;
    logic        desc_unused;

    assign desc_unused  = ^ctrl_fifo_rdata[63:17];
    assign word_keep    = data_fifo_rdata[KEEP_LSB +: 8];
    assign word_last    = data_fifo_rdata[LAST_BIT];
    assign byte_sum     = byte_cnt + {13'd0, popcount8(word_keep)};
    assign byte_cnt_new = (byte_sum > SAT_BYTES) ? SAT_BYTES : byte_sum;
    assign len_bad      = byte_cnt_new != {1'b0, frame_len};
    assign over_max     = byte_cnt_new > MAX_BYTES;

    // Pops decode registered state so a FWFT head can be taken every cycle; gating
    // with tx_resetn keeps both FIFOs untouched while they are being cleared.
    always_comb begin
        // NOTE: each combinational output is defaulted first so no path can infer a latch.
        ctrl_fifo_rden = 1'b0;
        data_fifo_rden = 1'b0;
        case (state)
            IDLE:    ctrl_fifo_rden = tx_resetn & enable & ~ctrl_fifo_empty;
            SEND:    data_fifo_rden = tx_resetn & ~data_fifo_empty & skid_ready;
            DROP:    data_fifo_rden = tx_resetn & ~data_fifo_empty;
            default: ;
        endcase
    end

    assign skid_valid   = data_fifo_rden & (state == SEND);
    assign skid_in.data = data_fifo_rdata[63:0];
    assign skid_in.keep = word_keep;
    assign skid_in.last = word_last | over_max;
    assign skid_in.user = word_last ? len_bad : over_max;

    ofm_axis_skid #(.WIDTH(BEAT_W)) u_skid (
        .clk       (tx_clk),
        .rst_n     (tx_resetn),
        .in_valid  (skid_valid),
        .in_data   (skid_in),
        .out_ready (skid_ready),
        .m_valid   (tx_axis_tvalid),
        .m_data    (skid_out),
        .m_ready   (tx_axis_tready),
        .empty     (skid_empty)
    );

    assign tx_axis_tdata = skid_out.data;
    assign tx_axis_tkeep = skid_out.keep;
    assign tx_axis_tlast = skid_out.last;
    assign tx_axis_tuser = skid_out.user;
    assign busy          = (state != IDLE) | ~skid_empty;

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            state         <= IDLE;
            frame_len     <= '0;
            frame_drop    <= 1'b0;
            byte_cnt      <= '0;
            gap_cnt       <= '0;
            len_err       <= 1'b0;
            stat_drops    <= '0;
            stat_len_errs <= '0;
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: if (ctrl_fifo_rden) begin
                    frame_len  <= ctrl_fifo_rdata[LEN_LSB +: LEN_W];
                    frame_drop <= ctrl_fifo_rdata[DROP_BIT];
                    state      <= LOAD;
                end
                LOAD: begin
                    byte_cnt <= '0;
                    if (frame_drop) begin
                        stat_drops <= stat_drops + 16'd1;
                        state      <= DROP;
                    end else begin
                        state <= SEND;
                    end
                end
                SEND: if (data_fifo_rden) begin
                    byte_cnt <= byte_cnt_new;
                    if (word_last) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                        if (len_bad) begin
                            len_err       <= 1'b1;
                            stat_len_errs <= stat_len_errs + 16'd1;
                        end
                    end else if (over_max) begin
                        // Truncated frame: the aborted beat is already out, discard the tail.
                        len_err       <= 1'b1;
                        stat_len_errs <= stat_len_errs + 16'd1;
                        state         <= DROP;
                    end
                end
                DROP: if (data_fifo_rden && word_last) begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: if (skid_empty) begin
                    if (gap_cnt == IFG_LAST) state <= IDLE;
                    else                     gap_cnt <= gap_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn)                                        stat_frames <= '0;
        else if (tx_axis_tvalid && tx_axis_tready && tx_axis_tlast) stat_frames <= stat_frames + 32'd1;
    end

endmodule

// File: tb/tb_ofm_tx_sched.sv
// Bench for ofm_tx_sched: FWFT FIFO models feed frames, a frame-level model predicts
// the beats into a scoreboard, and a monitor drains it as the MAC accepts beats.
`timescale 1ns/1ps
module tb_ofm_tx_sched;

    localparam int IFG  = 3;
    localparam int MAXB = 9600;

    logic        tx_clk = 1'b0;
    logic        tx_resetn = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] ctrl_fifo_rdata;
    logic        ctrl_fifo_empty, ctrl_fifo_rden;
    logic [72:0] data_fifo_rdata;
    logic        data_fifo_empty, data_fifo_rden;
    logic [63:0] tx_axis_tdata;
    logic [7:0]  tx_axis_tkeep;
    logic        tx_axis_tlast, tx_axis_tuser, tx_axis_tvalid, tx_axis_tready;
    logic        busy, len_err;
    logic [31:0] stat_frames;
    logic [15:0] stat_drops, stat_len_errs;

    always #5 tx_clk = ~tx_clk;

    ofm_tx_sched #(.C_IFG_CYCLES(IFG), .C_MAX_BYTES(MAXB)) dut (
        .tx_clk          (tx_clk),
        .tx_resetn       (tx_resetn),
        .enable          (enable),
        .ctrl_fifo_rdata (ctrl_fifo_rdata),
        .ctrl_fifo_empty (ctrl_fifo_empty),
        .ctrl_fifo_rden  (ctrl_fifo_rden),
        .data_fifo_rdata (data_fifo_rdata),
        .data_fifo_empty (data_fifo_empty),
        .data_fifo_rden  (data_fifo_rden),
        .tx_axis_tdata   (tx_axis_tdata),
        .tx_axis_tkeep   (tx_axis_tkeep),
        .tx_axis_tlast   (tx_axis_tlast),
        .tx_axis_tuser   (tx_axis_tuser),
        .tx_axis_tvalid  (tx_axis_tvalid),
        .tx_axis_tready  (tx_axis_tready),
        .busy            (busy),
        .len_err         (len_err),
        .stat_frames     (stat_frames),
        .stat_drops      (stat_drops),
        .stat_len_errs   (stat_len_errs)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] cq[$];
    logic [72:0] dq[$];
    logic [73:0] sb[$];

    int exp_frames = 0;
    int exp_drops  = 0;
    int exp_lerr   = 0;
    int obs_lerr   = 0;
    int beats_seen = 0;
    int rdy_mode   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge tx_clk);
            #2;
        end
    endtask

    // FWFT FIFOs: pop requests are sampled mid-cycle and applied just after the edge.
    initial begin : fifo_model
        bit c_pop, d_pop;
        ctrl_fifo_rdata = '0;
        ctrl_fifo_empty = 1'b1;
        data_fifo_rdata = '0;
        data_fifo_empty = 1'b1;
        forever begin
            @(negedge tx_clk);
            c_pop = ctrl_fifo_rden;
            d_pop = data_fifo_rden;
            if (c_pop) check("ctrl_pop_while_empty", ctrl_fifo_empty, 0);
            if (d_pop) check("data_pop_while_empty", data_fifo_empty, 0);
            @(posedge tx_clk);
            #1;
            if (c_pop && cq.size() > 0) void'(cq.pop_front());
            if (d_pop && dq.size() > 0) void'(dq.pop_front());
            ctrl_fifo_empty = (cq.size() == 0);
            ctrl_fifo_rdata = ctrl_fifo_empty ? 64'd0 : cq[0];
            data_fifo_empty = (dq.size() == 0);
            data_fifo_rdata = data_fifo_empty ? 73'd0 : dq[0];
        end
    end

    initial begin : ready_drv
        tx_axis_tready = 1'b0;
        forever begin
            @(posedge tx_clk);
            #2;
            case (rdy_mode)
                0:       tx_axis_tready = 1'b1;
                1:       tx_axis_tready = ~tx_axis_tready;
                default: tx_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin : monitor
        logic [73:0] got, exp, held;
        bit stalled, after_last;
        int idle;
        stalled = 0;
        after_last = 0;
        idle = 0;
        forever begin
            @(negedge tx_clk);
            if (!tx_resetn) begin
                stalled = 0;
                after_last = 0;
                obs_lerr = 0;
                continue;
            end
            got = {tx_axis_tuser, tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata};
            if (len_err) obs_lerr++;
            if (stalled) begin
                check("hold_tvalid", tx_axis_tvalid, 1);
                check("hold_payload", got, held);
            end
            if (tx_axis_tvalid) begin
                if (after_last) begin
                    check("ifg_idle_cycles_ok", idle >= IFG, 1);
                    after_last = 0;
                end
                if (tx_axis_tready) begin
                    beats_seen++;
                    if (sb.size() == 0) check("unexpected_beat_sb_size", sb.size(), 1);
                    else begin
                        exp = sb.pop_front();
                        check("beat", got, exp);
                    end
                    if (tx_axis_tlast) begin
                        after_last = 1;
                        idle = 0;
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = got;
                end
            end else begin
                stalled = 0;
                if (after_last) idle++;
            end
        end
    end

    // Frame-level model: bytes are summed per word; the frame ends at last, or is
    // aborted at the first word taking the count past MAXB.
    task automatic add_frame(input int len, input bit drop, input int nwords,
                             input logic [7:0] last_keep, input int lead, input int word_gap);
        logic [63:0] desc;
        logic [72:0] w;
        int cnt;
        bit done;
        desc = {$urandom(), $urandom()};
        desc[15:0] = len[15:0];
        desc[16] = drop;
        cq.push_back(desc);
        if (drop) exp_drops++;
        if (lead > 0) tick(lead);
        cnt = 0;
        done = drop;
        for (int i = 0; i < nwords; i++) begin
            w[63:0]  = {$urandom(), $urandom()};
            w[71:64] = (i == nwords - 1) ? last_keep : 8'hFF;
            w[72]    = (i == nwords - 1);
            dq.push_back(w);
            if (!done) begin
                cnt += $countones(w[71:64]);
                if (w[72]) begin
                    sb.push_back({(cnt != len), 1'b1, w[71:0]});
                    exp_frames++;
                    if (cnt != len) exp_lerr++;
                    done = 1;
                end else if (cnt > MAXB) begin
                    sb.push_back({1'b1, 1'b1, w[71:0]});
                    exp_frames++;
                    exp_lerr++;
                    done = 1;
                end else begin
                    sb.push_back({2'b00, w[71:0]});
                end
            end
            if (word_gap > 0 && $urandom_range(0, 1) == 1) tick(word_gap);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((cq.size() != 0 || dq.size() != 0 || sb.size() != 0 || busy) && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_drained_in_budget"}, n < budget, 1);
        tick(2);
    endtask

    task automatic check_stats(input string name);
        check({name, "_stat_frames"}, stat_frames, 32'(exp_frames));
        check({name, "_stat_drops"}, stat_drops, 16'(exp_drops));
        check({name, "_stat_len_errs"}, stat_len_errs, 16'(exp_lerr));
        check({name, "_len_err_pulses"}, obs_lerr, exp_lerr);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser, busy, len_err,
                               ctrl_fifo_rden, data_fifo_rden}, 0);
        check({name, "_tdata_tkeep"}, {tx_axis_tdata, tx_axis_tkeep}, 0);
        check({name, "_stats"}, {stat_frames, stat_drops, stat_len_errs}, 0);
    endtask

    initial begin : stim
        int base, n, nw, bytes, len;
        logic [7:0] lk;
        tick(3);
        check_reset_outputs("reset");
        tx_resetn = 1'b1;
        tick(2);
        enable = 1'b1;

        add_frame(64, 0, 8, 8'hFF, 0, 0);
        wait_drain("full_frame", 200);
        check_stats("full_frame");

        add_frame(60, 0, 8, 8'h0F, 0, 0);
        add_frame(64, 0, 8, 8'h0F, 0, 0);
        wait_drain("partial_keep", 200);
        check_stats("partial_keep");

        add_frame(32, 1, 4, 8'hFF, 0, 0);
        add_frame(40, 0, 5, 8'hFF, 0, 0);
        wait_drain("drop_flag", 200);
        check_stats("drop_flag");

        rdy_mode = 1;
        add_frame(128, 0, 16, 8'hFF, 3, 0);
        wait_drain("toggle_ready", 300);
        rdy_mode = 0;
        check_stats("toggle_ready");

        enable = 1'b0;
        add_frame(16, 0, 2, 8'hFF, 0, 0);
        tick(20);
        check("disabled_desc_kept", cq.size(), 1);
        check("disabled_not_busy", busy, 0);
        enable = 1'b1;
        wait_drain("enable_resume", 200);

        rdy_mode = 2;
        add_frame(96, 0, 12, 8'hFF, 0, 0);
        tick(4);
        enable = 1'b0;
        wait_drain("enable_drop_midframe", 300);
        enable = 1'b1;
        rdy_mode = 0;
        check_stats("enable_midframe");

        add_frame(9608, 0, 1206, 8'hFF, 0, 0);
        add_frame(24, 0, 3, 8'hFF, 0, 0);
        wait_drain("truncate", 3000);
        check_stats("truncate");

        rdy_mode = 2;
        repeat (25) begin
            nw = $urandom_range(1, 12);
            lk = 8'hFF >> $urandom_range(0, 7);
            bytes = (nw - 1) * 8 + $countones(lk);
            len = ($urandom_range(0, 3) == 0) ? bytes + 1 : bytes;
            add_frame(len, ($urandom_range(0, 5) == 0), nw, lk,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end
        wait_drain("random", 5000);
        rdy_mode = 0;
        check_stats("random");

        add_frame(80, 0, 10, 8'hFF, 0, 0);
        base = beats_seen;
        n = 0;
        while (beats_seen < base + 3 && n < 100) begin
            tick(1);
            n++;
        end
        check("midframe_reached_beat3", beats_seen >= base + 3, 1);
        tx_resetn = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        cq.delete();
        dq.delete();
        sb.delete();
        exp_frames = 0;
        exp_drops = 0;
        exp_lerr = 0;
        tick(3);
        tx_resetn = 1'b1;
        tick(1);
        check("post_reset_stats", {stat_frames, stat_drops, stat_len_errs}, 0);
        add_frame(48, 0, 6, 8'hFF, 0, 0);
        wait_drain("post_reset", 200);
        check_stats("post_reset");

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: run did not reach its summary, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
